io_uart: RTL and testbench

Memory-mapped UART peripheral on the CPU's IO port, downstream of the memory/IO controller. Consumes the controller's `ioCe`/`ioWe`/`ioAddr`/`ioWtData` strobes for the 0x7000_0000 IO window and returns `ioRdData` combinationally, so a load completes in the same cycle. Contains a TX FIFO feeding an 8N1 serializer and, optionally, an 8N1 receiver with a one-byte holding register.

---
 rtl/io_uart_pkg.sv | 19 +
 rtl/io_uart_if.sv | 10 +
 rtl/io_uart_tx_fifo.sv | 35 +++
 rtl/io_uart.sv | 163 ++++++++++++++++
 tb/tb_io_uart.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_uart_pkg.sv
// io_uart_pkg: register offsets, STATUS bit positions and FSM states shared by io_uart and its bench
package io_uart_pkg;
   localparam logic [1:0] UART_TXDATA = 2'd0;
   localparam logic [1:0] UART_RXDATA = 2'd1;
   localparam logic [1:0] UART_STATUS = 2'd2;
   localparam logic [1:0] UART_DIV    = 2'd3;
   localparam int UART_ST_TXFULL  = 0;
   localparam int UART_ST_TXEMPTY = 1;
   localparam int UART_ST_RXVALID = 2;
   localparam int UART_ST_RXOVR   = 3;
   localparam int UART_ST_TXBUSY  = 4;
   localparam int UART_ST_TXDROP  = 5;
   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;
endpackage

// File: rtl/io_uart_if.sv
// io_uart_if: CPU IO-port strobes for the UART window and the combinational read-data return
interface io_uart_if;
   logic        ioCe;
   logic        ioWe;
   logic [31:0] ioAddr;
   logic [31:0] ioWtData;
   logic [31:0] ioRdData;
   modport master (output ioCe, ioWe, ioAddr, ioWtData, input ioRdData);
   modport slave (input ioCe, ioWe, ioAddr, ioWtData, output ioRdData);
endinterface

// File: rtl/io_uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with wrap-bit pointers; a push while full is taken only alongside a pop
module uart_tx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic [7:0] wdata_i,
   output logic [7:0] rdata_o,
   output logic       full_o,
   output logic       empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0] mem_q [DEPTH];
   logic [AW:0] wr_q, rd_q;
   logic do_push, do_pop;
   assign empty_o = wr_q == rd_q;
   assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign rdata_o = mem_q[rd_q[AW-1:0]];
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
      end
   end
endmodule

// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART, TX FIFO + serializer; receiver and RX holding register only with UART_RX_EN
module io_uart import io_uart_pkg::*; #(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic     clk,
   input  logic     rst,
   io_uart_if.slave bus,
   input  logic     uartRx,
   output logic     uartTx
);
   logic [1:0] reg_sel;
   logic acc_rd, acc_wr, push, pop, full, empty, drop;
   logic [7:0] fifo_rdata, rx_byte;
   logic rx_valid, rx_ovr, tx_drop_q;
   logic [15:0] div_q;
   uart_state_e state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shift_q, shift_d;
   logic tx_q, tx_d;
   logic [5:0] status;
   logic unused_bus;
   assign reg_sel = bus.ioAddr[3:2];
   assign acc_rd = bus.ioCe & ~bus.ioWe;
   assign acc_wr = bus.ioCe & bus.ioWe;
   assign push = acc_wr && reg_sel == UART_TXDATA;
   assign drop = push & full & ~pop;
   assign unused_bus = ^{bus.ioAddr[31:4], bus.ioAddr[1:0], bus.ioWtData[31:16]};
   assign uartTx = tx_q;
   uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk, .rst, .push_i(push), .pop_i(pop), .wdata_i(bus.ioWtData[7:0]),
      .rdata_o(fifo_rdata), .full_o(full), .empty_o(empty)
   );
   // uartTx is registered from the state, so each frame appears one cycle after the FSM enters START
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      idx_d = idx_q;
      shift_d = shift_q;
      pop = 1'b0;
      tx_d = state_q == UART_START ? 1'b0 : state_q == UART_DATA ? shift_q[0] : 1'b1;
      if (state_q == UART_IDLE || (state_q == UART_STOP && cnt_q == '0)) begin
         pop = ~empty;
         state_d = empty ? UART_IDLE : UART_START;
         shift_d = fifo_rdata;
         cnt_d = div_q;
      end else if (cnt_q != '0) cnt_d = cnt_q - 16'd1;
      else begin
         cnt_d = div_q;
         idx_d = state_q == UART_START ? 3'd0 : idx_q + 3'd1;
         if (state_q == UART_DATA) shift_d = shift_q >> 1;
         state_d = (state_q == UART_DATA && idx_q == 3'd7) ? UART_STOP : UART_DATA;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= UART_IDLE;
         cnt_q <= '0;
         idx_q <= '0;
         shift_q <= '0;
         tx_q <= 1'b1;
         div_q <= DEFAULT_DIV;
         tx_drop_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         shift_q <= shift_d;
         tx_q <= tx_d;
         if (acc_wr && reg_sel == UART_DIV) div_q <= bus.ioWtData[15:0];
         tx_drop_q <= drop | (tx_drop_q & ~(acc_wr && reg_sel == UART_STATUS && bus.ioWtData[UART_ST_TXDROP]));
      end
   end
`ifdef UART_RX_EN
   logic rx_s1_q, rx_s2_q, rx_prev_q, rx_valid_q, rx_ovr_q, rx_done, rd_rx, clr_ovr;
   uart_state_e rstate_q, rstate_d;
   logic [15:0] rcnt_q, rcnt_d;
   logic [2:0] ridx_q, ridx_d;
   logic [7:0] rshift_q, rshift_d, rx_byte_q;
   assign rd_rx = acc_rd && reg_sel == UART_RXDATA;
   assign clr_ovr = acc_wr && reg_sel == UART_STATUS && bus.ioWtData[UART_ST_RXOVR];
   always_comb begin
      rstate_d = rstate_q;
      rcnt_d = rcnt_q;
      ridx_d = ridx_q;
      rshift_d = rshift_q;
      rx_done = 1'b0;
      if (rstate_q == UART_IDLE) begin
         if (rx_prev_q & ~rx_s2_q) begin
            rcnt_d = {1'b0, div_q[15:1]};
            rstate_d = UART_START;
         end
      end else if (rcnt_q != '0) rcnt_d = rcnt_q - 16'd1;
      else begin
         rcnt_d = div_q;
         case (rstate_q)
            UART_START: begin
               ridx_d = '0;
               rstate_d = rx_s2_q ? UART_IDLE : UART_DATA;
            end
            UART_DATA: begin
               rshift_d = {rx_s2_q, rshift_q[7:1]};
               ridx_d = ridx_q + 3'd1;
               if (ridx_q == 3'd7) rstate_d = UART_STOP;
            end
            default: begin
               rx_done = rx_s2_q;
               rstate_d = UART_IDLE;
            end
         endcase
      end
   end
   // a completing frame beats a same-cycle RXDATA read: valid stays set and no overrun is flagged
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_prev_q <= 1'b1;
         rstate_q <= UART_IDLE;
         rcnt_q <= '0;
         ridx_q <= '0;
         rshift_q <= '0;
         rx_byte_q <= '0;
         rx_valid_q <= 1'b0;
         rx_ovr_q <= 1'b0;
      end else begin
         rx_s1_q <= uartRx;
         rx_s2_q <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         rstate_q <= rstate_d;
         rcnt_q <= rcnt_d;
         ridx_q <= ridx_d;
         rshift_q <= rshift_d;
         if (rx_done) rx_byte_q <= rshift_q;
         rx_valid_q <= rx_done | (rx_valid_q & ~rd_rx);
         rx_ovr_q <= (rx_done & rx_valid_q & ~rd_rx) | (rx_ovr_q & ~clr_ovr);
      end
   end
   assign rx_byte = rx_byte_q;
   assign rx_valid = rx_valid_q;
   assign rx_ovr = rx_ovr_q;
`else
   logic unused_rx;
   assign unused_rx = uartRx;
   assign rx_byte = '0;
   assign rx_valid = 1'b0;
   assign rx_ovr = 1'b0;
`endif
   always_comb begin
      status = '0;
      status[UART_ST_TXFULL] = full;
      status[UART_ST_TXEMPTY] = empty;
      status[UART_ST_RXVALID] = rx_valid;
      status[UART_ST_RXOVR] = rx_ovr;
      status[UART_ST_TXBUSY] = state_q != UART_IDLE;
      status[UART_ST_TXDROP] = tx_drop_q;
   end
   assign bus.ioRdData = !acc_rd ? '0 :
      reg_sel == UART_RXDATA ? {24'd0, rx_byte} :
      reg_sel == UART_STATUS ? {26'd0, status} :
      reg_sel == UART_DIV ? {16'd0, div_q} : '0;
endmodule

// File: tb/tb_io_uart.sv
// tb_io_uart: randomized bench for io_uart against a frame-level model; RX expectations follow UART_RX_EN
module tb_io_uart;
   import io_uart_pkg::*;
   localparam int DEPTH = 8;
`ifdef UART_RX_EN
   localparam bit RX_EN = 1'b1;
`else
   localparam bit RX_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uartRx = 1'b1;
   logic uartTx;
   io_uart_if bus();
   io_uart #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd433)) dut (
      .clk(clk), .rst(rst), .bus(bus), .uartRx(uartRx), .uartTx(uartTx)
   );
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int bdiv = 433;
   bit mon_on = 1'b1;
   int frame_err = 0;
   logic [7:0] tx_seen[$];
   logic [7:0] tx_exp[$];
   logic m_valid = 1'b0;
   logic m_ovr = 1'b0;
   logic m_drop = 1'b0;
   logic [7:0] m_byte = 8'h00;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_status(bit full, bit empty, bit busy);
      return {26'd0, m_drop, busy, m_ovr, m_valid, empty, full};
   endfunction

   task automatic wr(logic [1:0] r, logic [31:0] d);
      bus.ioCe = 1'b1;
      bus.ioWe = 1'b1;
      bus.ioAddr = {4'h7, 24'($urandom), r, 2'($urandom)};
      bus.ioWtData = d;
      @(negedge clk);
      bus.ioCe = 1'b0;
      bus.ioWe = 1'b0;
   endtask

   task automatic rd(logic [1:0] r, output logic [31:0] d);
      bus.ioCe = 1'b1;
      bus.ioWe = 1'b0;
      bus.ioAddr = {4'h7, 24'($urandom), r, 2'($urandom)};
      #1 d = bus.ioRdData;
      @(negedge clk);
      bus.ioCe = 1'b0;
   endtask

   task automatic rchk(string tag, logic [1:0] r, logic [31:0] e);
      logic [31:0] d;
      rd(r, d);
      chk(tag, d, e);
   endtask

   task automatic rx_read(string tag);
      logic [31:0] d;
      rd(UART_RXDATA, d);
      chk(tag, d, {24'h0, m_byte});
      m_valid = 1'b0;
   endtask

   task automatic set_div(int v);
      wr(UART_DIV, 32'(v));
      bdiv = v;
   endtask

   task automatic wait_drain(string tag);
      logic [31:0] s;
      int t = 0;
      do begin
         rd(UART_STATUS, s);
         t++;
      end while (!(s[1] && !s[4]) && t < 5000);
      chk(tag, {63'd0, s[1] && !s[4]}, 64'd1);
      repeat (bdiv + 4) @(negedge clk);
   endtask

   task automatic check_tx(string tag);
      chk({tag, "_count"}, tx_seen.size(), tx_exp.size());
      for (int i = 0; i < tx_exp.size() && i < tx_seen.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), tx_seen[i], tx_exp[i]);
      chk({tag, "_framing"}, frame_err, 0);
      tx_seen.delete();
      tx_exp.delete();
      frame_err = 0;
   endtask

   task automatic send_rx(logic [7:0] v, bit stop);
      logic [9:0] f = {stop, v, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uartRx = f[i];
         repeat (bdiv + 1) @(negedge clk);
      end
      uartRx = 1'b1;
      repeat (3) @(negedge clk);
      if (RX_EN && stop) begin
         m_ovr = m_ovr | m_valid;
         m_byte = v;
         m_valid = 1'b1;
      end
   endtask

   // decodes every frame on uartTx by sampling mid-bit at the current divisor
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on && uartTx === 1'b0) begin
            automatic int b = bdiv + 1;
            automatic logic [7:0] v = '0;
            automatic logic ok;
            repeat (b / 2) @(negedge clk);
            ok = (uartTx === 1'b0);
            for (int k = 0; k < 8; k++) begin
               repeat (b) @(negedge clk);
               v[k] = uartTx;
            end
            repeat (b) @(negedge clk);
            if (!(ok && uartTx === 1'b1)) frame_err++;
            tx_seen.push_back(v);
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [63:0] txv, bv, exv, exb;
      logic [7:0] fr;
      int bn, lows;
      bus.ioCe = 1'b0;
      bus.ioWe = 1'b0;
      bus.ioAddr = '0;
      bus.ioWtData = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      bus.ioAddr = {28'h0, UART_DIV, 2'b00};
      #1 chk("rd_no_ce", bus.ioRdData, 0);
      chk("rst_tx", uartTx, 1);
      rchk("rst_status", UART_STATUS, 32'h2);
      rchk("rst_div", UART_DIV, 32'd433);
      rchk("rst_rxdata", UART_RXDATA, 0);
      rchk("rd_txdata", UART_TXDATA, 0);
      bus.ioCe = 1'b1;
      bus.ioWe = 1'b1;
      bus.ioAddr = {28'h0, UART_DIV, 2'b00};
      bus.ioWtData = 32'hFFFF_0003;
      #1 chk("rd_on_write", bus.ioRdData, 0);
      @(negedge clk);
      bus.ioCe = 1'b0;
      bus.ioWe = 1'b0;
      bdiv = 3;
      rchk("div_rw", UART_DIV, 32'd3);

      // exact 0x55 waveform and txBusy window, sample i taken after edge N+i
      fr = 8'h55;
      wr(UART_TXDATA, 32'h55);
      tx_exp.push_back(fr);
      bus.ioCe = 1'b1;
      bus.ioWe = 1'b0;
      bus.ioAddr = {28'h0, UART_STATUS, 2'b00};
      txv = '0;
      bv = '0;
      for (int i = 0; i < 44; i++) begin
         #1;
         txv[i] = uartTx;
         bv[i] = bus.ioRdData[4];
         @(negedge clk);
      end
      bus.ioCe = 1'b0;
      exv = '0;
      exb = '0;
      for (int i = 0; i < 44; i++) begin
         bn = (i - 2) / 4;
         exv[i] = (i < 2 || i >= 42) ? 1'b1 : bn == 0 ? 1'b0 : bn == 9 ? 1'b1 : fr[bn-1];
         exb[i] = (i >= 1 && i <= 40);
      end
      chk("tx55_wave", txv, exv);
      chk("tx55_busy", bv, exb);
      chk("tx55_busy_len", $countones(bv), 40);
      wait_drain("tx55_drain");
      check_tx("tx55");

      for (int b = 0; b < 11; b++) begin
         wr(UART_TXDATA, {24'($urandom), 8'(b)});
         if (b < DEPTH + 1) tx_exp.push_back(8'(b));
         else m_drop = 1'b1;
         if (b == DEPTH) rchk("burst_full", UART_STATUS, m_status(1, 0, 1));
      end
      rchk("drop_set", UART_STATUS, m_status(1, 0, 1));
      wr(UART_STATUS, 32'h20);
      m_drop = 1'b0;
      rchk("drop_clr", UART_STATUS, m_status(1, 0, 1));
      wait_drain("burst_drain");
      check_tx("burst");

      for (int r = 0; r < 4; r++) begin
         set_div($urandom_range(2, 6));
         for (int n = $urandom_range(1, DEPTH); n > 0; n--) begin
            fr = 8'($urandom);
            wr(UART_TXDATA, {24'($urandom), fr});
            tx_exp.push_back(fr);
         end
         wait_drain($sformatf("rand%0d_drain", r));
         check_tx($sformatf("rand%0d", r));
      end

      set_div(3);
      send_rx(8'hA3, 1'b1);
      rchk("rx_a3_status", UART_STATUS, m_status(0, 1, 0));
      rx_read("rx_a3_data");
      rchk("rx_a3_clr", UART_STATUS, m_status(0, 1, 0));
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      rchk("rx_ovr_status", UART_STATUS, m_status(0, 1, 0));
      rx_read("rx_ovr_data");
      wr(UART_STATUS, 32'h08);
      m_ovr = 1'b0;
      rchk("rx_ovr_clr", UART_STATUS, m_status(0, 1, 0));
      uartRx = 1'b0;
      @(negedge clk);
      uartRx = 1'b1;
      repeat (20) @(negedge clk);
      rchk("rx_glitch", UART_STATUS, m_status(0, 1, 0));
      send_rx(8'h5A, 1'b0);
      rchk("rx_badstop_status", UART_STATUS, m_status(0, 1, 0));
      rx_read("rx_badstop_data");
      for (int i = 0; i < 6; i++) begin
         set_div($urandom_range(2, 6));
         send_rx(8'($urandom), 1'b1);
         rchk($sformatf("rx_rand%0d_status", i), UART_STATUS, m_status(0, 1, 0));
         if ($urandom_range(0, 1) == 1) rx_read($sformatf("rx_rand%0d_data", i));
      end

      // reset during the 4th data bit of 0xC3 (a low bit) with a second byte still queued
      mon_on = 1'b0;
      set_div(3);
      wr(UART_TXDATA, 32'hC3);
      wr(UART_TXDATA, 32'h01);
      repeat (18) @(negedge clk);
      #1 chk("tx_mid_frame", uartTx, 0);
      rst = 1'b1;
      @(negedge clk);
      #1 chk("tx_after_rst", uartTx, 1);
      rst = 1'b0;
      bdiv = 433;
      m_valid = 1'b0;
      m_ovr = 1'b0;
      m_byte = 8'h00;
      rchk("rst_mid_status", UART_STATUS, 32'h2);
      rchk("rst_mid_div", UART_DIV, 32'd433);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (uartTx !== 1'b1) lows++;
      end
      chk("rst_fifo_lost", lows, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
